load_store_unit: RTL and testbench

- Memory-access stage that sits directly upstream of the single-port 16-bit data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and returns one response per request.
- Converts byte addresses to memory word addresses and drives the memory's shared address/write port (memory read is combinational off the same address).
- Byte stores are done as a read-merge-write sequence; all memory-side outputs come from registered state.

---
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of a single-port 16-bit data
// memory. Loads take two cycles. Word stores take two cycles. Byte stores are
// done as read-merge-write and take three cycles. A misaligned word access is
// answered with an error after one cycle.
// Optional feature macro: LSU_SEXT_EN. When it is defined, byte loads are
// sign-extended. When it is undefined, byte loads are zero-extended.
module load_store_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_RMW  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  lane_reg;   // 1 = upper byte [15:8]
  logic                  byte_reg;   // load is a byte access

  logic [7:0]            sel_byte;
  logic [DATA_WIDTH-1:0] ext_byte;
  logic [DATA_WIDTH-1:0] merged;

  // Memory-side outputs come straight from registers. The write enable is
  // additionally masked by rst, so a reset during WR never commits a write.
  assign req_ready   = (state == S_IDLE);
  assign mem_addr    = addr_reg;
  assign mem_wr_data = wdata_reg;
  assign mem_wr_en   = (state == S_WR) & ~rst;

  // Byte-lane select and extension for loads, and byte merge for stores.
  always_comb begin
    sel_byte = lane_reg ? mem_rd_data[15:8] : mem_rd_data[7:0];
`ifdef LSU_SEXT_EN
    ext_byte = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
`else
    ext_byte = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
`endif
    merged   = lane_reg ? {wdata_reg[7:0], mem_rd_data[7:0]}
                        : {mem_rd_data[15:8], wdata_reg[7:0]};
  end

  // Control FSM, request capture and response generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      lane_reg  <= 1'b0;
      byte_reg  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (!req_byte && req_addr[0]) begin
              // Misaligned word access: answer at once and do not touch memory.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              addr_reg <= {1'b0, req_addr[ADDR_WIDTH-1:1]};
              lane_reg <= req_addr[0];
              byte_reg <= req_byte;
              if (!req_we) begin
                state <= S_RD;
              end else if (!req_byte) begin
                wdata_reg <= req_wdata;
                state     <= S_WR;
              end else begin
                wdata_reg[7:0] <= req_wdata[7:0];
                state          <= S_RMW;
              end
            end
          end
        end
        S_RD: begin
          rsp_rdata <= byte_reg ? ext_byte : mem_rd_data;
          rsp_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_RMW: begin
          wdata_reg <= merged;
          state     <= S_WR;
        end
        S_WR: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against load_store_unit.
// A byte-addressed reference memory predicts every result. A 256-word array
// in the bench acts as the data memory that the DUT drives.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;

  logic [15:0] mem [256];   // physical memory attached to the DUT
  logic [7:0]  rb  [512];   // reference memory, one entry per byte

  int pass_cnt = 0;
  int total_cnt = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[7:0]];

  // Single-port memory: write at the clock edge, read combinationally.
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    logic [8:0] w;
    w = {a[8:1], 1'b0};
    return {rb[w + 9'd1], rb[w]};
  endfunction

  // Issue one request, update the reference model and check the full transaction.
  task automatic do_req(input logic we, input logic by, input logic [15:0] a,
                        input logic [15:0] wd);
    logic        err;
    int          lat;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic [7:0]  b;
    int          wr_cnt;
    int          wr_cyc;
    int          rsp_cyc;
    logic [15:0] wr_addr;
    logic [15:0] wr_dat;
    logic [15:0] got_rd;
    logic        got_err;
    err    = !by && a[0];
    exp_rd = 16'h0;
    exp_wr = 16'h0;
    if (!err && !we) begin
      if (by) begin
        b = rb[a[8:0]];
`ifdef LSU_SEXT_EN
        exp_rd = {{8{b[7]}}, b};
`else
        exp_rd = {8'h00, b};
`endif
      end else begin
        exp_rd = ref_word(a);
      end
    end else if (!err) begin
      if (by) begin
        rb[a[8:0]] = wd[7:0];
      end else begin
        rb[{a[8:1], 1'b0}] = wd[7:0];
        rb[{a[8:1], 1'b1}] = wd[15:8];
      end
      exp_wr = ref_word(a);
    end
    lat = err ? 1 : (!we ? 2 : (by ? 3 : 2));

    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_byte = by; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    wr_cnt = 0; wr_cyc = 0; rsp_cyc = 0;
    wr_addr = 0; wr_dat = 0; got_rd = 0; got_err = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !err) chk("mem_addr", mem_addr, {1'b0, a[15:1]});
      if (mem_wr_en) begin
        wr_cnt++; wr_cyc = k; wr_addr = mem_addr; wr_dat = mem_wr_data;
      end
      if (rsp_valid && rsp_cyc == 0) begin
        rsp_cyc = k; got_rd = rsp_rdata; got_err = rsp_err;
      end
    end
    chk("ready_back", req_ready, 1);
    chk("rsp_latency", rsp_cyc, lat);
    chk("rsp_err", got_err, err);
    chk("rsp_rdata", got_rd, exp_rd);
    chk("wr_count", wr_cnt, (we && !err) ? 1 : 0);
    if (we && !err) begin
      chk("wr_cycle", wr_cyc, lat - 1);
      chk("wr_addr", wr_addr, {1'b0, a[15:1]});
      chk("wr_data", wr_dat, exp_wr);
    end
  endtask

  initial begin
    logic [15:0] keep;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 512; i++) rb[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_wr_data", mem_wr_data, 16'h0);

    // Directed sequence
    do_req(1, 0, 16'h0010, 16'hBEEF);
    do_req(0, 0, 16'h0010, 16'h0000);
    do_req(1, 1, 16'h0011, 16'h005A);
    do_req(0, 0, 16'h0010, 16'h0000);
    do_req(1, 1, 16'h0011, 16'h1280);
    do_req(0, 1, 16'h0011, 16'h0000);
    do_req(0, 1, 16'h0010, 16'h0000);
    do_req(0, 0, 16'h0010, 16'h0000);
    do_req(1, 0, 16'h0013, 16'h1234);
    @(negedge clk);
    chk("misaligned_mem_unchanged", mem[9], ref_word(16'h0012));
    do_req(1, 0, 16'h01FE, 16'hC3A5);
    do_req(0, 1, 16'hFFFF, 16'h0000);
    do_req(0, 1, 16'hFFFE, 16'h0000);

    // Reset asserted during the WR cycle of a byte store
    keep = ref_word(16'h0010);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1;
    req_addr = 16'h0010; req_wdata = 16'h0033;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_en", mem_wr_en, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rsp_valid2", rsp_valid, 0);
    chk("rst_mid_mem", mem[8], keep);
    do_req(0, 0, 16'h0010, 16'h0000);

    // Random traffic across 256 words
    for (int i = 0; i < 60; i++)
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 511)), 16'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
